// File: rtl/lfsr_rng.sv
// Galois LFSR random source with runtime reseed and lock-up recovery.
// Includes a handshaked draw engine that returns values bounded to a range.
module lfsr_rng #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'h71,
    parameter logic [WIDTH-1:0] SEED      = 8'hD7,
    parameter int unsigned      MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] rand_out,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_range,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_folded
);

    localparam int unsigned TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        HOLD
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] range_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] range_m1;
    logic [WIDTH-1:0] cand;
    logic [TW-1:0]    try_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_folded_q;
    logic             resp_valid_q;
    logic             req_ready_q;
    logic             accept;
    logic             last_try;

    // All-zero is the Galois lock-up state; recover to the seed.
    always_comb begin
        step = SEED;
        if (lfsr_q != '0) begin
            step = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? TAPS : '0);
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = (seed_in == '0) ? SEED : seed_in;
        end else if (en || state_q == DRAW) begin
            lfsr_d = step;
        end
    end

    // Smear R-1 downward; R=0 wraps to all ones, i.e. the full range.
    always_comb begin
        range_m1 = req_range - WIDTH'(1);
        mask_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask_d[i] = |(range_m1 >> i);
        end
    end

    assign cand     = lfsr_q & mask_q;
    assign accept   = (range_q == '0) || (cand < range_q);
    assign last_try = (try_q == TW'(MAX_TRIES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            lfsr_q        <= SEED;
            range_q       <= '0;
            mask_q        <= '0;
            try_q         <= '0;
            resp_data_q   <= '0;
            resp_folded_q <= 1'b0;
            resp_valid_q  <= 1'b0;
            req_ready_q   <= 1'b1;
        end else begin
            lfsr_q <= lfsr_d;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        range_q     <= req_range;
                        mask_q      <= mask_d;
                        try_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= DRAW;
                    end
                end
                DRAW: begin
                    if (accept) begin
                        resp_data_q   <= cand;
                        resp_folded_q <= 1'b0;
                        resp_valid_q  <= 1'b1;
                        state_q       <= HOLD;
                    end else if (last_try) begin
                        // mask <= 2(R-1), so one subtraction lands below R
                        resp_data_q   <= cand - range_q;
                        resp_folded_q <= 1'b1;
                        resp_valid_q  <= 1'b1;
                        state_q       <= HOLD;
                    end else begin
                        try_q <= try_q + TW'(1);
                    end
                end
                HOLD: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rand_out    = lfsr_q;
    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_folded = resp_folded_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng: stepping, period, reseed, draws, stalls, reset.
// Expected values are worked by hand from the x^8+x^6+x^5+x^4+1 sequence.
module tb_lfsr_rng;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       seed_load;
    logic [7:0] seed_in;
    logic [7:0] rand_out;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_range;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_folded;

    int n_cmp = 0;
    int n_bad = 0;

    lfsr_rng dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .seed_load(seed_load),
        .seed_in(seed_in),
        .rand_out(rand_out),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_range(req_range),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data),
        .resp_folded(resp_folded)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reseed(input logic [7:0] s);
        seed_in   = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    // One handshake edge, then run until resp_valid; cyc counts that edge.
    task automatic draw(input logic [7:0] r, output int cyc);
        req_range = r;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    int cyc;
    int zero_seen;

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        seed_load  = 1'b0;
        seed_in    = 8'h00;
        req_valid  = 1'b0;
        req_range  = 8'h00;
        resp_ready = 1'b0;
        #3;
        chk("rst_rand", rand_out, 8'hD7);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_valid", resp_valid, 1'b0);
        chk("rst_data", resp_data, 8'h00);
        chk("rst_fold", resp_folded, 1'b0);
        tick();
        rst = 1'b0;

        en = 1'b1;
        tick();
        chk("step1", rand_out, 8'hDF);
        tick();
        chk("step2", rand_out, 8'hCF);
        en = 1'b0;

        reseed(8'h00);
        chk("seed_zero", rand_out, 8'hD7);

        en = 1'b1;
        zero_seen = 0;
        for (int i = 1; i < 255; i++) begin
            tick();
            if (rand_out == 8'h00 || rand_out == 8'hD7) zero_seen++;
        end
        tick();
        en = 1'b0;
        chk("period_early", zero_seen, 0);
        chk("period_255", rand_out, 8'hD7);

        reseed(8'h3C);
        chk("seed_3c", rand_out, 8'h3C);
        reseed(8'h00);

        resp_ready = 1'b1;
        req_range  = 8'd10;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("r10_hs_valid", resp_valid, 1'b0);
        chk("r10_hs_ready", req_ready, 1'b0);
        chk("r10_hs_rand", rand_out, 8'hD7);
        tick();
        chk("r10_valid", resp_valid, 1'b1);
        chk("r10_data", resp_data, 8'd7);
        chk("r10_fold", resp_folded, 1'b0);
        chk("r10_rand", rand_out, 8'hDF);
        tick();
        chk("r10_done_valid", resp_valid, 1'b0);
        chk("r10_done_ready", req_ready, 1'b1);

        reseed(8'h00);
        draw(8'd5, cyc);
        chk("r5_latency", cyc, 5);
        chk("r5_data", resp_data, 8'd2);
        chk("r5_fold", resp_folded, 1'b1);
        chk("r5_rand", rand_out, 8'hAF);
        tick();

        draw(8'd1, cyc);
        chk("r1_data", resp_data, 8'd0);
        chk("r1_fold", resp_folded, 1'b0);
        tick();

        reseed(8'h00);
        draw(8'd0, cyc);
        chk("r0_latency", cyc, 2);
        chk("r0_data", resp_data, 8'hD7);
        tick();

        reseed(8'h00);
        en = 1'b1;
        req_range = 8'd10;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("en_hs_rand", rand_out, 8'hDF);
        tick();
        chk("en_draw_rand", rand_out, 8'hCF);
        en  = 1'b0;
        cyc = 2;
        while (!resp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("en_latency", cyc, 5);
        chk("en_data", resp_data, 8'd5);
        chk("en_fold", resp_folded, 1'b1);
        chk("en_rand", rand_out, 8'h2F);
        tick();

        resp_ready = 1'b0;
        reseed(8'h00);
        draw(8'd10, cyc);
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", resp_valid, 1'b1);
            chk("stall_data", resp_data, 8'd7);
            chk("stall_ready", req_ready, 1'b0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        chk("stall_release", resp_valid, 1'b0);

        reseed(8'h3C);
        req_range = 8'd2;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_valid", resp_valid, 1'b0);
        chk("midrst_rand", rand_out, 8'hD7);
        chk("midrst_ready", req_ready, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("midrst_no_resp", resp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
- Parametrised Galois LFSR pseudo-random generator with runtime reseed, lock-up protection and a bounded-range draw engine.
- The draw engine uses a valid/ready handshake and returns uniform values in [0, range-1] by masked rejection sampling, with a guaranteed latency cap.
- Serves game-logic consumers, e.g. new-tile value and position selection, replacing the fixed 8-bit generator.

Parameters:
- WIDTH, 8, LFSR and data width (4..32).
- TAPS, 8'h71, Galois feedback mask; bit i set means the MSB is XORed into next[i]. Bit 0 must be set. Default is x^8+x^6+x^5+x^4+1.
- SEED, 8'hD7, reset and fallback state. Must be nonzero.
- MAX_TRIES, 4, maximum evaluations per draw before fold fallback (>=1).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous reset, active-high.
- en, input, 1, free-run advance enable.
- seed_load, input, 1, load seed_in on the next edge.
- seed_in, input, WIDTH, runtime seed; 0 means use SEED.
- rand_out, output, WIDTH, current LFSR state (registered).
- req_valid, input, 1, draw request.
- req_ready, output, 1, engine idle and accepting.
- req_range, input, WIDTH, range for the draw, captured on handshake.
- resp_valid, output, 1, draw result available.
- resp_ready, input, 1, consumer accepts result.
- resp_data, output, WIDTH, draw result.
- resp_folded, output, 1, result produced by fold fallback.

Behaviour:
- Reset (async, rst=1):
  - rand_out=SEED, FSM=IDLE, req_ready=1.
  - resp_valid=0, resp_data=0, resp_folded=0, try counter=0.
  - Reset mid-draw aborts the draw; no response is issued.
- Step function:
  - next = {s[WIDTH-2:0],1'b0} ^ (s[WIDTH-1] ? TAPS : 0).
  - An all-zero state steps to SEED (lock-up recovery).
- LFSR update priority per edge:
  - seed_load: state = (seed_in==0) ? SEED : seed_in.
  - else if (en || FSM==DRAW): state = next.
  - else hold.
- FSM states:
  - IDLE: req_ready=1. On req_valid: capture range R and compute mask M, then go to DRAW with the try counter cleared. The LFSR does not advance on the handshake edge unless en=1.
  - DRAW: req_ready=0. Each cycle, evaluate cand = rand_out & M from the current (pre-edge) state, and the LFSR advances.
    - Accept if cand < R: resp_data=cand, resp_folded=0, go to HOLD.
    - On the MAX_TRIES-th evaluation with cand >= R: resp_data=cand-R, resp_folded=1, go to HOLD.
    - Otherwise increment the try counter and stay in DRAW.
  - HOLD: resp_valid=1; resp_data and resp_folded are stable. When resp_ready=1, go to IDLE on that edge; resp_valid=0 and req_ready=1 the next cycle.
- Mask M: smallest 2^k-1 >= R-1.
  - R=1 gives M=0, so the result is always 0.
  - R=0 means full range: M=all ones, always accepted, resp_data=rand_out.
- Fold result is always < R, because M <= 2(R-1).
- Latency:
  - Handshake edge to resp_valid high is 2 cycles minimum.
  - Maximum is MAX_TRIES+1 cycles.
- seed_load during DRAW:
  - The current evaluation uses the old state.
  - Later evaluations use the loaded seed.
- en has no effect on FSM timing; the LFSR steps once per cycle whether en=1 or the FSM is in DRAW, never twice.
- resp_ready outside HOLD is ignored; req_valid outside IDLE is ignored.

Test Plan:
- Reset then en=1 for 2 cycles -> rand_out 0xD7, 0xDF, 0xCF.
- en=1 continuously for 255 steps -> rand_out returns to 0xD7 exactly at step 255 and is never 0 in between.
- seed_load=1, seed_in=0x00 -> rand_out=0xD7. seed_load=1, seed_in=0x3C -> rand_out=0x3C.
- en=0, state 0xD7, request R=10, resp_ready=1 -> resp_valid high 2 cycles after the handshake, resp_data=7, resp_folded=0, rand_out=0xDF afterwards.
- State 0xD7, R=5, MAX_TRIES=4 -> candidates from 0xD7, 0xDF, 0xCF, 0xEF are all 7 and rejected; resp_data=2, resp_folded=1, latency 5 cycles, rand_out=0xAF.
- R=1 -> resp_data=0. R=0 -> resp_data=0xD7.
- Hold resp_ready=0 for 3 cycles -> data stays stable and req_ready=0.
- Assert rst in DRAW -> resp_valid=0 and rand_out=0xD7 immediately.
